// File: rtl/test_unit_pkg.sv
// Shared definitions for the test_unit status block.
//   W_DEF / CNT_W_DEF : default operand and event-counter widths
//   flags_t           : per-sample flag bundle (eq, gt, lt, win, par, ovf)
//   cmp_t             : result of one ordered comparison (gt, lt, eq)
//   cmp4()            : width-generic unsigned/signed comparison
//   parity32()        : XOR-reduction parity helper
package test_unit_pkg;

    localparam int unsigned W_DEF     = 32'd4;
    localparam int unsigned CNT_W_DEF = 32'd4;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
        logic win;
        logic par;
        logic ovf;
    } flags_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_t;

    // Operands arrive zero-extended. In signed mode the sign bit (bit w-1) is
    // flipped, which maps two's-complement values onto an order-preserving
    // unsigned key, so one unsigned compare serves both modes.
    function automatic cmp_t cmp4(input logic [31:0] x,
                                  input logic [31:0] y,
                                  input int unsigned w,
                                  input logic        signed_mode);
        logic [31:0] flip_v;
        logic [31:0] xk_v;
        logic [31:0] yk_v;
        cmp_t        res_v;
        flip_v   = 32'(signed_mode) << (w - 32'd1);
        xk_v     = x ^ flip_v;
        yk_v     = y ^ flip_v;
        res_v.gt = (xk_v > yk_v);
        res_v.lt = (xk_v < yk_v);
        res_v.eq = (xk_v == yk_v);
        return res_v;
    endfunction

    // Zero-extension does not change XOR parity, so any width up to 32 fits.
    function automatic logic parity32(input logic [31:0] x);
        return ^x;
    endfunction

endpackage

// File: rtl/test_unit_if.sv
// Operand/flag bundle of test_unit.
//   a..g : strobe, clear, mode, count enable and operands (driven by master)
//   h..q : registered status flags (driven by the test_unit slave)
interface test_unit_if #(
    parameter int unsigned W = test_unit_pkg::W_DEF
);
    logic         a;
    logic         b;
    logic         c;
    logic         d;
    logic [W-1:0] e;
    logic [W-1:0] f;
    logic [W-1:0] g;
    logic         h;
    logic         i;
    logic         j;
    logic         l;
    logic         m;
    logic         n;
    logic         o;
    logic         p;
    logic         q;

    modport master (
        output a, b, c, d, e, f, g,
        input  h, i, j, l, m, n, o, p, q
    );

    modport slave (
        input  a, b, c, d, e, f, g,
        output h, i, j, l, m, n, o, p, q
    );
endinterface

// File: rtl/test_unit_cmp.sv
// Combinational comparator: x versus y, unsigned or two's-complement.
//   x, y        : W-bit operands
//   signed_mode : 0 = unsigned, 1 = signed
//   res         : gt / lt / eq of x relative to y (exactly one is set)
module test_unit_cmp
    import test_unit_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         signed_mode,
    output cmp_t         res
);

    // Single comparison through the shared package function.
    always_comb begin
        res = cmp4(32'(x), 32'(y), W, signed_mode);
    end

endmodule

// File: rtl/test_unit.sv
// Registered operand comparator and flag generator.
//   clk : system clock, all state on the rising edge
//   rst : synchronous active-high reset
//   bus : test_unit_if slave; a strobes e/f/g into flags h,i,j,l,m,n,
//         b clears sticky o and the event counter, c selects signed compare,
//         d enables counting, o is sticky equality, p is counter >= g,
//         q is the registered strobe.
module test_unit
    import test_unit_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic  clk,
    input  logic  rst,
    test_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cmp_t           ef_s;
    cmp_t           lo_s;
    cmp_t           hi_s;
    logic [W-1:0]   lo_bound_s;
    logic [W-1:0]   hi_bound_s;
    logic [W+1:0]   sum_s;
    flags_t         flags_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic           o_next_s;
    logic           thr_s;
    logic           unused_s;

    flags_t         flags_r;
    logic [CNT_W-1:0] cnt_r;
    logic           o_r;
    logic           p_r;
    logic           q_r;

    test_unit_cmp #(.W(W)) u_cmp_ef (
        .x           (bus.e),
        .y           (bus.f),
        .signed_mode (bus.c),
        .res         (ef_s)
    );

    test_unit_cmp #(.W(W)) u_cmp_lo (
        .x           (bus.g),
        .y           (lo_bound_s),
        .signed_mode (bus.c),
        .res         (lo_s)
    );

    test_unit_cmp #(.W(W)) u_cmp_hi (
        .x           (bus.g),
        .y           (hi_bound_s),
        .signed_mode (bus.c),
        .res         (hi_s)
    );

    // Order the window bounds so the probe is always tested against [min, max].
    always_comb begin
        if (ef_s.gt) begin
            lo_bound_s = bus.f;
            hi_bound_s = bus.e;
        end else begin
            lo_bound_s = bus.e;
            hi_bound_s = bus.f;
        end
    end

    // Per-sample flag values from the live operands.
    always_comb begin
        sum_s       = {2'b00, bus.e} + {2'b00, bus.f} + {2'b00, bus.g};
        flags_s.eq  = ef_s.eq;
        flags_s.gt  = ef_s.gt;
        flags_s.lt  = ef_s.lt;
        flags_s.win = ~lo_s.lt & ~hi_s.gt;
        flags_s.par = parity32(32'(bus.e ^ bus.f ^ bus.g));
        flags_s.ovf = |sum_s[W+1:W];
    end

    // Next counter, sticky flag and threshold; clear beats increment/set.
    always_comb begin
        if (bus.b) begin
            cnt_next_s = '0;
        end else if (bus.a && bus.d && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_next_s = cnt_r;
        end

        if (bus.b) begin
            o_next_s = 1'b0;
        end else if (bus.a && ef_s.eq) begin
            o_next_s = 1'b1;
        end else begin
            o_next_s = o_r;
        end

        thr_s = (32'(cnt_next_s) >= 32'(bus.g));
    end

    // Comparator bits the window test does not need, and the low sum bits.
    assign unused_s = ^{lo_s.gt, lo_s.eq, hi_s.lt, hi_s.eq, sum_s[W-1:0]};

    // State registers; reset discards every pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= '0;
            cnt_r   <= '0;
            o_r     <= 1'b0;
            p_r     <= 1'b0;
            q_r     <= 1'b0;
        end else begin
            if (bus.a) begin
                flags_r <= flags_s;
            end else begin
                flags_r <= flags_r;
            end
            cnt_r <= cnt_next_s;
            o_r   <= o_next_s;
            p_r   <= thr_s;
            q_r   <= bus.a;
        end
    end

    assign bus.h = flags_r.eq;
    assign bus.i = flags_r.gt;
    assign bus.j = flags_r.lt;
    assign bus.l = flags_r.win;
    assign bus.m = flags_r.par;
    assign bus.n = flags_r.ovf;
    assign bus.o = o_r;
    assign bus.p = p_r;
    assign bus.q = q_r;

endmodule

// File: tb/tb_test_unit.sv
// Directed self-checking bench for test_unit; expected values hand-computed.
module tb_test_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    test_unit_if #(.W(4)) bus ();

    test_unit #(.W(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {h,i,j,l,m,n,o,p,q}
    function automatic logic [8:0] outs();
        return {bus.h, bus.i, bus.j, bus.l, bus.m, bus.n, bus.o, bus.p, bus.q};
    endfunction

    function automatic logic [5:0] flags6();
        return {bus.h, bus.i, bus.j, bus.l, bus.m, bus.n};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        // Reset held with an active sample and e == f.
        rst = 1'b1;
        bus.a = 1'b1; bus.b = 1'b0; bus.c = 1'b0; bus.d = 1'b0;
        bus.e = 4'd3; bus.f = 4'd3; bus.g = 4'd0;
        step(); step();
        check_eq("reset_outs", 32'(outs()), 32'h000);

        // Release with g=0: only p rises.
        rst = 1'b0; bus.a = 1'b0; bus.e = 4'd0; bus.f = 4'd0;
        step();
        check_eq("release_outs", 32'(outs()), 32'(9'b000000010));

        // Unsigned: 15 > 1, parity(E)=1, sum 16 overflows.
        bus.c = 1'b0; bus.e = 4'hF; bus.f = 4'h1; bus.g = 4'h0; bus.a = 1'b1;
        step();
        check_eq("unsigned_outs", 32'(outs()), 32'(9'b010011011));
        bus.a = 1'b0;
        step();
        check_eq("q_pulse_end", 32'(bus.q), 32'd0);

        // Signed: -1 < 1, and 0 lies in [-1, 1].
        bus.c = 1'b1; bus.a = 1'b1;
        step();
        check_eq("signed_i", 32'(bus.i), 32'd0);
        check_eq("signed_j", 32'(bus.j), 32'd1);
        check_eq("signed_l", 32'(bus.l), 32'd1);
        bus.a = 1'b0;
        step();

        // Window with swapped bounds: 5 in [2,9]; 9^2^5=E; sum 16; cnt 0 < 5.
        bus.c = 1'b0; bus.e = 4'd9; bus.f = 4'd2; bus.g = 4'd5; bus.a = 1'b1;
        step();
        check_eq("win_in_outs", 32'(outs()), 32'(9'b010111001));
        bus.g = 4'd10;
        step();
        check_eq("win_out_l", 32'(bus.l), 32'd0);
        check_eq("win_out_m", 32'(bus.m), 32'd1);
        bus.e = 4'd0; bus.f = 4'd0; bus.g = 4'd0;
        step();
        check_eq("zero_outs", 32'(outs()), 32'(9'b100100111));

        // Sticky equality and clear.
        bus.a = 1'b0; bus.b = 1'b1;
        step();
        check_eq("clear_o", 32'(bus.o), 32'd0);
        bus.b = 1'b0; bus.a = 1'b1; bus.e = 4'd7; bus.f = 4'd7;
        step();
        check_eq("sticky_set_h", 32'(bus.h), 32'd1);
        check_eq("sticky_set_o", 32'(bus.o), 32'd1);
        bus.e = 4'd1; bus.f = 4'd2;
        step();
        check_eq("sticky_hold_h", 32'(bus.h), 32'd0);
        check_eq("sticky_hold_o", 32'(bus.o), 32'd1);
        bus.b = 1'b1; bus.e = 4'd5; bus.f = 4'd5;
        step();
        check_eq("clear_wins_o", 32'(bus.o), 32'd0);
        check_eq("clear_wins_h", 32'(bus.h), 32'd1);

        // Counter threshold g=3 from cnt=0.
        bus.b = 1'b0; bus.g = 4'd3; bus.d = 1'b1; bus.e = 4'd1; bus.f = 4'd2;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_eq($sformatf("cnt_thr_%0d", k), 32'(bus.p), (k >= 3) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            check_eq($sformatf("cnt_sat_%0d", k), 32'(bus.p), 32'd1);
        end
        // Saturated at 15: a wrap would drop below g=15.
        bus.g = 4'd15;
        step();
        check_eq("cnt_max_p", 32'(bus.p), 32'd1);
        bus.a = 1'b0; bus.d = 1'b0;
        step();
        check_eq("cnt_max_hold_p", 32'(bus.p), 32'd1);
        bus.g = 4'd3; bus.b = 1'b1;
        step();
        check_eq("cnt_clear_p", 32'(bus.p), 32'd0);
        bus.b = 1'b0;
        step();
        check_eq("cnt_cleared_p", 32'(bus.p), 32'd0);

        // Hold: last sample was e=1,f=2,g=15 -> h0 i0 j1 l0 m0 n1.
        for (int k = 0; k < 10; k++) begin
            bus.e = 4'($urandom_range(15, 0));
            bus.f = 4'($urandom_range(15, 0));
            bus.g = 4'($urandom_range(15, 0));
            bus.c = 1'($urandom_range(1, 0));
            step();
            check_eq($sformatf("hold_flags_%0d", k), 32'(flags6()), 32'(6'b001001));
            check_eq($sformatf("hold_q_%0d", k), 32'(bus.q), 32'd0);
        end

        // Reset mid-operation discards a pending sample and count.
        bus.a = 1'b1; bus.d = 1'b1; bus.c = 1'b0; bus.e = 4'd7; bus.f = 4'd7; bus.g = 4'd1;
        rst = 1'b1;
        step();
        check_eq("mid_reset_outs", 32'(outs()), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/test_unit.md
Name: test_unit

Overview:
- Registered 4-bit operand comparator and flag generator.
- Samples three 4-bit operands (e, f, g) on a strobe and produces nine single-bit status flags one cycle later.
- Flags cover equality/ordering, window check, parity and sum overflow, plus a sticky equality flag and a saturating event counter with threshold.
- Sits as a leaf status block feeding control logic; purely synchronous.

Parameters:
- W, 4, operand width of e/f/g (all arithmetic below scales with W).
- CNT_W, 4, event counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  sample strobe; operands captured and flags h..n updated when 1.
- b  input  1  clear; zeroes sticky flag o and event counter.
- c  input  1  compare mode: 0 = unsigned, 1 = two's-complement signed.
- d  input  1  count enable; counter increments on edges where a=1 and d=1.
- e  input  W  operand A.
- f  input  W  operand B.
- g  input  W  operand C (window probe, sum term, counter threshold).
- h  output 1  e == f (registered).
- i  output 1  e > f per mode c.
- j  output 1  e < f per mode c.
- l  output 1  g inside the inclusive window [min(e,f), max(e,f)] per mode c.
- m  output 1  XOR-reduction parity of (e ^ f ^ g).
- n  output 1  overflow: unsigned sum e+f+g exceeds 2^W-1.
- o  output 1  sticky equality: set on any sample with e==f, held until b or rst.
- p  output 1  counter threshold: next counter value >= g (unsigned).
- q  output 1  valid: one-cycle pulse following each sample (registered a).

Behaviour:
- rst=1 at an edge: all outputs h..q = 0, counter = 0. rst overrides a, b, d.
- Sample edge (a=1, rst=0): h, i, j, l, m, n load values computed from the current e/f/g/c. These are visible on the cycle after the edge (latency 1).
- a=0: h, i, j, l, m, n hold their last value.
- Exactly one of h/i/j is 1 after any sample.
- Signed mode applies to i, j and l only. h, m, n, p are mode-independent.
- Window l: the bounds are swapped automatically when e > f. When e == f, l = (g == e).
- Overflow n: computed at W+2 bits. For W=4, n=1 iff e+f+g > 15.
- q: equals the value of a at the previous edge; q=0 after reset.
- Sticky o:
  - b=1 clears o to 0, taking priority over a set in the same cycle.
  - Otherwise o sets to 1 on a sample with e==f.
  - Otherwise o holds.
- Counter cnt:
  - b=1 clears cnt to 0, taking priority over increment.
  - Otherwise a&d increments cnt, saturating at 15 with no wrap.
  - Otherwise cnt holds.
- p: updated every cycle (not gated by a) as registered (cnt_next >= live g). With g=0, p=1 from the first edge after reset release.
- Reset asserted mid-operation: all state is discarded at that edge; no partial update.

Decomposition:
- Shared package test_unit_pkg holds:
  - W and CNT_W defaults.
  - A flags struct type (eq, gt, lt, win, par, ovf).
  - A function cmp4(x, y, signed_mode) returning gt/lt/eq.
- One natural sub-module: test_unit_cmp, the combinational comparator. Instantiate it twice: for e vs f, and for the window bounds vs g.
- Counter and sticky logic stay in the top level.

Test Plan:
- Reset: hold rst=1 for 2 cycles with a=1, e=f=3 -> all outputs 0. Release rst with g=0 -> p=1 the next cycle, all other outputs 0.
- Unsigned vs signed compare:
  - c=0, e=4'hF, f=4'h1, a pulse -> i=1, j=0, h=0, q=1 for one cycle.
  - Repeat with c=1 -> i=0, j=1.
- Window, parity, overflow:
  - e=9, f=2, g=5, c=0, a=1 -> l=1, m=parity(9^2^5=4'hE)=1, n=1 (sum 16).
  - g=10 -> l=0.
  - e=f=g=0 -> l=1, m=0, n=0, h=1.
- Sticky and clear:
  - Sample e=f=7 -> h=1, o=1.
  - Sample e=1, f=2 -> h=0, o stays 1.
  - b=1 with a=1, e=f -> o=0 (clear wins).
- Counter saturation/threshold:
  - g=3, a=d=1 for 3 edges -> p=1 after the 3rd edge.
  - Continue for 20 edges -> p stays 1, no wrap.
  - Then b=1 -> p=0 next cycle.
- Hold: a=0 while e/f/g toggle randomly for 10 cycles -> h, i, j, l, m, n unchanged; q=0.
